// File: rtl/code_lock_param_if.sv
// rtl/code_lock_param_if.sv - keypad-side and actuator-side signal bundle for code_lock_param
interface code_lock_param_if #(
    parameter int DIGIT_W  = 4,
    parameter int CODE_LEN = 4
);
    localparam int CNT_W = $clog2(CODE_LEN + 1);

    logic               enter;
    logic [DIGIT_W-1:0] digit;
    logic               program_en;
    logic               lock;
    logic               unlocked;
    logic               locked_out;
    logic               fail;
    logic               prog_done;
    logic [CNT_W-1:0]   digit_cnt;

    modport master (
        output enter, digit, program_en, lock,
        input  unlocked, locked_out, fail, prog_done, digit_cnt
    );

    modport slave (
        input  enter, digit, program_en, lock,
        output unlocked, locked_out, fail, prog_done, digit_cnt
    );
endinterface

// File: rtl/code_lock_param.sv
// rtl/code_lock_param.sv - parametrised combination lock with lockout, auto-relock and reprogramming
module code_lock_param #(
    parameter int                           DIGIT_W        = 4,
    parameter int                           CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE   = 16'h9979,
    parameter int                           MAX_FAILS      = 3,
    parameter int                           LOCKOUT_CYCLES = 64,
    parameter int                           UNLOCK_CYCLES  = 128
) (
    input  logic             clk,
    input  logic             reset,
    code_lock_param_if.slave bus
);
    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0]  LAST_DIGIT   = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] LAST_FAIL    = FAIL_W'(MAX_FAILS - 1);
    localparam logic [TMR_W-1:0]  UNLOCK_LAST  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_UNLOCKED,
        S_PROGRAM,
        S_LOCKOUT
    } state_t;

    state_t             state, state_d;
    logic               enter_q;
    logic [CODE_W-1:0]  code_reg, code_d;
    logic [CODE_W-1:0]  shadow, shadow_d;
    logic [CODE_W-1:0]  cmp_sh, cmp_d;
    logic               mismatch, mismatch_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [FAIL_W-1:0]  fail_cnt, fail_cnt_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic               unlocked_q, unlocked_d;
    logic               locked_out_q, locked_out_d;
    logic               fail_q, fail_d;
    logic               prog_done_q, prog_done_d;

    logic               accept;
    logic [CODE_W-1:0]  cmp_cur;
    logic [CODE_W-1:0]  shadow_next;
    logic               digit_bad;

    assign accept      = bus.enter & ~enter_q;
    // Expected digits are consumed from a shifting copy of the code; the first digit reads code_reg directly.
    assign cmp_cur     = (cnt == '0) ? code_reg : cmp_sh;
    assign digit_bad   = bus.digit != cmp_cur[CODE_W-1 -: DIGIT_W];
    assign shadow_next = (shadow << DIGIT_W) | CODE_W'(bus.digit);

    always_comb begin
        state_d      = state;
        code_d       = code_reg;
        shadow_d     = shadow;
        cmp_d        = cmp_sh;
        mismatch_d   = mismatch;
        cnt_d        = cnt;
        fail_cnt_d   = fail_cnt;
        timer_d      = timer;
        fail_d       = 1'b0;
        prog_done_d  = 1'b0;

        case (state)
            S_LOCKED: begin
                if (accept) begin
                    if (cnt == LAST_DIGIT) begin
                        cnt_d      = '0;
                        mismatch_d = 1'b0;
                        timer_d    = '0;
                        if (!(mismatch | digit_bad)) begin
                            state_d    = S_UNLOCKED;
                            fail_cnt_d = '0;
                        end else begin
                            fail_d     = 1'b1;
                            fail_cnt_d = fail_cnt + 1'b1;
                            if (fail_cnt == LAST_FAIL) begin
                                state_d = S_LOCKOUT;
                            end
                        end
                    end else begin
                        cnt_d      = cnt + 1'b1;
                        mismatch_d = mismatch | digit_bad;
                        cmp_d      = cmp_cur << DIGIT_W;
                    end
                end
            end

            S_UNLOCKED: begin
                if (bus.lock || timer == UNLOCK_LAST) begin
                    state_d = S_LOCKED;
                end else if (accept) begin
                    timer_d = '0;
                    if (bus.program_en) begin
                        if (CODE_LEN == 1) begin
                            code_d      = CODE_W'(bus.digit);
                            prog_done_d = 1'b1;
                            state_d     = S_LOCKED;
                        end else begin
                            shadow_d = CODE_W'(bus.digit);
                            cnt_d    = CNT_W'(1);
                            state_d  = S_PROGRAM;
                        end
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end

            S_PROGRAM: begin
                if (bus.lock || timer == UNLOCK_LAST) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                end else if (accept) begin
                    timer_d = '0;
                    if (cnt == LAST_DIGIT) begin
                        code_d      = shadow_next;
                        prog_done_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_LOCKED;
                    end else begin
                        shadow_d = shadow_next;
                        cnt_d    = cnt + 1'b1;
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end

            S_LOCKOUT: begin
                if (timer == LOCKOUT_LAST) begin
                    state_d    = S_LOCKED;
                    fail_cnt_d = '0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end

            default: begin
                state_d = S_LOCKED;
                cnt_d   = '0;
            end
        endcase

        unlocked_d   = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
        locked_out_d = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_LOCKED;
            enter_q      <= 1'b0;
            code_reg     <= DEFAULT_CODE;
            shadow       <= '0;
            cmp_sh       <= '0;
            mismatch     <= 1'b0;
            cnt          <= '0;
            fail_cnt     <= '0;
            timer        <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            fail_q       <= 1'b0;
            prog_done_q  <= 1'b0;
        end else begin
            state        <= state_d;
            enter_q      <= bus.enter;
            code_reg     <= code_d;
            shadow       <= shadow_d;
            cmp_sh       <= cmp_d;
            mismatch     <= mismatch_d;
            cnt          <= cnt_d;
            fail_cnt     <= fail_cnt_d;
            timer        <= timer_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
            fail_q       <= fail_d;
            prog_done_q  <= prog_done_d;
        end
    end

    assign bus.unlocked   = unlocked_q;
    assign bus.locked_out = locked_out_q;
    assign bus.fail       = fail_q;
    assign bus.prog_done  = prog_done_q;
    assign bus.digit_cnt  = cnt;
endmodule

// File: tb/tb_code_lock_param.sv
// tb/tb_code_lock_param.sv - directed bench with a digit-queue reference model for code_lock_param
module tb_code_lock_param;
    localparam int          DIGIT_W        = 4;
    localparam int          CODE_LEN       = 4;
    localparam logic [15:0] DEFAULT_CODE   = 16'h9979;
    localparam int          MAX_FAILS      = 3;
    localparam int          LOCKOUT_CYCLES = 64;
    localparam int          UNLOCK_CYCLES  = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    code_lock_param_if #(.DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN)) bus();

    code_lock_param #(
        .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEFAULT_CODE),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0 locked, 1 unlocked, 2 program, 3 lockout.
    int m_mode = 0;
    int m_code[CODE_LEN];
    int m_entry[$];
    int m_new[$];
    int m_fails = 0;
    int m_idle = 0;
    bit m_enter_q = 1'b0;
    bit m_fail = 1'b0;
    bit m_done = 1'b0;

    always @(posedge clk) begin : model
        bit acc;
        bit ok;
        acc = bus.enter && !m_enter_q;
        m_enter_q = bus.enter;
        m_fail = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_mode = 0;
            for (int i = 0; i < CODE_LEN; i++)
                m_code[i] = int'((DEFAULT_CODE >> (DIGIT_W * (CODE_LEN - 1 - i))) & 16'hF);
            m_entry.delete();
            m_new.delete();
            m_fails = 0;
            m_idle = 0;
            m_enter_q = 1'b0;
        end else begin
            case (m_mode)
                0: if (acc) begin
                    m_entry.push_back(int'(bus.digit));
                    if (m_entry.size() == CODE_LEN) begin
                        ok = 1'b1;
                        foreach (m_entry[i]) if (m_entry[i] != m_code[i]) ok = 1'b0;
                        m_entry.delete();
                        m_idle = 0;
                        if (ok) begin
                            m_mode = 1;
                            m_fails = 0;
                        end else begin
                            m_fail = 1'b1;
                            m_fails++;
                            if (m_fails == MAX_FAILS) m_mode = 3;
                        end
                    end
                end
                1: if (bus.lock) m_mode = 0;
                   else begin
                       m_idle++;
                       if (m_idle == UNLOCK_CYCLES) m_mode = 0;
                       else if (acc) begin
                           m_idle = 0;
                           if (bus.program_en) begin
                               m_new.delete();
                               m_new.push_back(int'(bus.digit));
                               m_mode = 2;
                           end
                       end
                   end
                2: if (bus.lock) begin
                       m_mode = 0;
                       m_new.delete();
                   end else begin
                       m_idle++;
                       if (m_idle == UNLOCK_CYCLES) begin
                           m_mode = 0;
                           m_new.delete();
                       end else if (acc) begin
                           m_idle = 0;
                           m_new.push_back(int'(bus.digit));
                           if (m_new.size() == CODE_LEN) begin
                               foreach (m_new[i]) m_code[i] = m_new[i];
                               m_new.delete();
                               m_done = 1'b1;
                               m_mode = 0;
                           end
                       end
                   end
                default: begin
                    m_idle++;
                    if (m_idle == LOCKOUT_CYCLES) begin
                        m_mode = 0;
                        m_fails = 0;
                    end
                end
            endcase
        end
    end

    int fail_seen = 0;
    int done_seen = 0;
    int lo_cycles = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("unlocked", int'(bus.unlocked), int'(m_mode == 1 || m_mode == 2));
            check("locked_out", int'(bus.locked_out), int'(m_mode == 3));
            check("fail", int'(bus.fail), int'(m_fail));
            check("prog_done", int'(bus.prog_done), int'(m_done));
            check("digit_cnt", int'(bus.digit_cnt),
                  (m_mode == 0) ? m_entry.size() : (m_mode == 2) ? m_new.size() : 0);
            if (bus.fail === 1'b1) fail_seen++;
            if (bus.prog_done === 1'b1) done_seen++;
            if (bus.locked_out === 1'b1) lo_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        bus.digit = DIGIT_W'(d);
        bus.enter = 1'b1;
        tick(1);
        bus.enter = 1'b0;
        tick(1);
    endtask

    task automatic code4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) press(int'(c[15 - 4 * i -: 4]));
    endtask

    task automatic relock();
        bus.lock = 1'b1;
        tick(1);
        bus.lock = 1'b0;
    endtask

    task automatic pulse_reset();
        bus.enter = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        int f0;
        bus.enter = 1'b0;
        bus.digit = '0;
        bus.program_en = 1'b0;
        bus.lock = 1'b0;
        tick(1);
        chk_en = 1'b1;
        check("reset_unlocked", int'(bus.unlocked), 0);
        check("reset_digit_cnt", int'(bus.digit_cnt), 0);
        reset = 1'b0;

        // T1: default code opens
        f0 = fail_seen;
        code4(16'h9979);
        check("t1_unlocked", int'(bus.unlocked), 1);
        check("t1_no_fail", fail_seen - f0, 0);
        relock();
        check("t1_relock", int'(bus.unlocked), 0);

        // T2: wrong code then right code
        f0 = fail_seen;
        code4(16'h1234);
        check("t2_fail_pulses", fail_seen - f0, 1);
        check("t2_unlocked", int'(bus.unlocked), 0);
        code4(16'h9979);
        check("t2_unlocked_after", int'(bus.unlocked), 1);
        relock();

        // T3: lockout after three wrong codes
        f0 = fail_seen;
        code4(16'h1111);
        code4(16'h2222);
        lo_cycles = 0;
        code4(16'h1234);
        check("t3_fail_pulses", fail_seen - f0, 3);
        check("t3_locked_out", int'(bus.locked_out), 1);
        code4(16'h9979);
        check("t3_ignored_unlocked", int'(bus.unlocked), 0);
        check("t3_ignored_cnt", int'(bus.digit_cnt), 0);
        for (int i = 0; i < 200 && bus.locked_out; i++) tick(1);
        check("t3_lockout_ended", int'(bus.locked_out), 0);
        check("t3_lockout_len", lo_cycles, LOCKOUT_CYCLES);
        code4(16'h9979);
        check("t3_unlocked", int'(bus.unlocked), 1);

        // T4: reprogram to 1234
        f0 = done_seen;
        bus.program_en = 1'b1;
        code4(16'h1234);
        bus.program_en = 1'b0;
        check("t4_prog_done", done_seen - f0, 1);
        check("t4_locked", int'(bus.unlocked), 0);
        f0 = fail_seen;
        code4(16'h9979);
        check("t4_old_code_fails", fail_seen - f0, 1);
        code4(16'h1234);
        check("t4_new_code_opens", int'(bus.unlocked), 1);

        // T5: auto-relock, explicit relock, held enter
        tick(120);
        check("t5_still_open", int'(bus.unlocked), 1);
        tick(10);
        check("t5_timed_out", int'(bus.unlocked), 0);
        code4(16'h1234);
        check("t5_reopened", int'(bus.unlocked), 1);
        relock();
        check("t5_lock_next_edge", int'(bus.unlocked), 0);
        bus.digit = 4'd1;
        bus.enter = 1'b1;
        tick(5);
        check("t5_held_enter", int'(bus.digit_cnt), 1);
        bus.enter = 1'b0;
        tick(1);

        // T6: reset mid-entry and mid-program
        press(2);
        check("t6_two_digits", int'(bus.digit_cnt), 2);
        pulse_reset();
        check("t6_cnt_cleared", int'(bus.digit_cnt), 0);
        code4(16'h9979);
        check("t6_default_restored", int'(bus.unlocked), 1);
        bus.program_en = 1'b1;
        press(5);
        press(6);
        bus.program_en = 1'b0;
        check("t6_mid_program_cnt", int'(bus.digit_cnt), 2);
        pulse_reset();
        check("t6_prog_reset_unlocked", int'(bus.unlocked), 0);
        check("t6_prog_reset_cnt", int'(bus.digit_cnt), 0);
        code4(16'h9979);
        check("t6_default_after_prog", int'(bus.unlocked), 1);
        tick(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
